// File: rtl/f_max_unpool_pkg.sv
// Shared types and fill-value selection for the max-unpool unit.
// Build option: F_MAX_UNPOOL_NEG_FILL_EN selects most-negative fill instead of zero.
package f_max_unpool_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_t;

  localparam logic [63:0] FILL_ZERO = '0;

`ifdef F_MAX_UNPOOL_NEG_FILL_EN
  localparam bit NEG_FILL = 1'b1;
`else
  localparam bit NEG_FILL = 1'b0;
`endif

  // Most-negative fill lets a downstream max-pool recover negative pooled values.
  function automatic logic [63:0] fill_value(input int data_w);
    if (NEG_FILL) return 64'(1) << (data_w - 1);
    return FILL_ZERO;
  endfunction

endpackage

// File: rtl/f_unpool_window_ctr.sv
// Control FSM for max-unpool: start delay down-counter and per-window position counter.
module f_unpool_window_ctr
  import f_max_unpool_pkg::*;
#(
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [DELAY_W-1:0] stride_minus_one,
  output logic [DELAY_W-1:0] pos,
  output logic               window_start,
  output logic               stream_active
);

  state_t             state;
  logic [DELAY_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pos   <= '0;
    end else if (run) begin
      pos <= '0;
      if (delay0 != '0) begin
        state <= WAIT;
        cnt   <= delay0;
      end else begin
        state <= STREAM;
      end
    end else if (running) begin
      case (state)
        WAIT: begin
          cnt <= cnt - DELAY_W'(1);
          if (cnt == DELAY_W'(1)) begin
            state <= STREAM;
            pos   <= '0;
          end
        end
        STREAM: begin
          if (pos == stride_minus_one) pos <= '0;
          else                         pos <= pos + DELAY_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign stream_active = (state == STREAM);
  assign window_start  = stream_active && (pos == '0);

endmodule

// File: rtl/f_max_unpool.sv
// Max-unpool: expands one pooled value per window into strideMinusOne+1 words,
// value at the argmax position and fill elsewhere. Option: F_MAX_UNPOOL_NEG_FILL_EN.
module f_max_unpool
  import f_max_unpool_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0] delay0,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DELAY_W-1:0] in1,
  output logic [DATA_W-1:0]  out0,
  output logic               oob
);

  localparam logic [DATA_W-1:0] FILL = DATA_W'(fill_value(DATA_W));

  logic [DELAY_W-1:0] pos;
  logic               window_start;
  logic               stream_active;
  logic [DATA_W-1:0]  val;
  logic [DELAY_W-1:0] idx;
  logic [DATA_W-1:0]  eval;
  logic [DELAY_W-1:0] eidx;

  f_unpool_window_ctr #(.DELAY_W(DELAY_W)) u_ctr (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .running          (running),
    .delay0           (delay0),
    .stride_minus_one (strideMinusOne),
    .pos              (pos),
    .window_start     (window_start),
    .stream_active    (stream_active)
  );

  // Bypass at window start so the first word needs no extra cycle of latency.
  assign eval = window_start ? in0 : val;
  assign eidx = window_start ? in1 : idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val  <= '0;
      idx  <= '0;
      out0 <= '0;
      oob  <= 1'b0;
    end else if (run) begin
      oob <= 1'b0;
    end else if (running) begin
      if (stream_active) begin
        if (window_start) begin
          val <= in0;
          idx <= in1;
          if (in1 > strideMinusOne) oob <= 1'b1;
        end
        // Out-of-range index never matches pos, so that window is all fill.
        out0 <= (pos == eidx) ? eval : FILL;
      end else begin
        out0 <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_f_max_unpool.sv
// Directed self-checking bench for f_max_unpool (both fill builds).
module tb_f_max_unpool;

  localparam int DATA_W  = 32;
  localparam int DELAY_W = 7;

`ifdef F_MAX_UNPOOL_NEG_FILL_EN
  localparam logic [31:0] F = 32'h8000_0000;
`else
  localparam logic [31:0] F = 32'h0000_0000;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               run;
  logic               running;
  logic [DELAY_W-1:0] strideMinusOne;
  logic [DELAY_W-1:0] delay0;
  logic [DATA_W-1:0]  in0;
  logic [DELAY_W-1:0] in1;
  logic [DATA_W-1:0]  out0;
  logic               oob;

  int total = 0;
  int bad   = 0;

  f_max_unpool #(.DATA_W(DATA_W), .DELAY_W(DELAY_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .run            (run),
    .running        (running),
    .strideMinusOne (strideMinusOne),
    .delay0         (delay0),
    .in0            (in0),
    .in1            (in1),
    .out0           (out0),
    .oob            (oob)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run(input logic [DELAY_W-1:0] d);
    delay0 = d;
    run    = 1'b1;
    tick();
    run    = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_a[4];
    logic [31:0] exp_b[4];

    rst = 1'b1; run = 1'b0; running = 1'b0;
    strideMinusOne = '0; delay0 = '0; in0 = '0; in1 = '0;
    #12;
    chk("reset_out0", out0, 32'h0);
    chk("reset_oob", {31'b0, oob}, 32'h0);
    rst = 1'b0;
    tick();

    // delay0=2, 4-wide window, argmax 2
    running = 1'b1; strideMinusOne = 7'd3;
    pulse_run(7'd2);
    chk("run_hold_out0", out0, 32'h0);
    tick(); chk("wait0", out0, F);
    tick(); chk("wait1", out0, F);
    in0 = 32'h7; in1 = 7'd2;
    exp_a = '{F, F, 32'h7, F};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        tick(); chk($sformatf("win_r%0d_p%0d", r, i), out0, exp_a[i]);
      end
    chk("win_oob", {31'b0, oob}, 32'h0);

    // stall at pos 2 with out0 holding the value word, in0 changes meanwhile
    pulse_run(7'd0);
    in0 = 32'h7; in1 = 7'd1;
    tick(); chk("stall_p0", out0, F);
    tick(); chk("stall_p1", out0, 32'h7);
    running = 1'b0; in0 = 32'h9;
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("stall_hold%0d", i), out0, 32'h7);
    end
    running = 1'b1;
    exp_b = '{F, F, F, 32'h9};
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("resume%0d", i), out0, exp_b[i]);
    end

    // out-of-range index sets oob; run at pos 2 abandons the window and clears it
    pulse_run(7'd0);
    in0 = 32'h5; in1 = 7'd5;
    tick(); chk("oob_p0", out0, F);
    chk("oob_set", {31'b0, oob}, 32'h1);
    tick(); chk("oob_p1", out0, F);
    pulse_run(7'd1);
    chk("abandon_oob_clr", {31'b0, oob}, 32'h0);
    in1 = 7'd2;
    tick(); chk("abandon_wait", out0, F);
    exp_a = '{F, F, 32'h5, F};
    for (int i = 0; i < 4; i++) begin
      tick(); chk($sformatf("restart_p%0d", i), out0, exp_a[i]);
    end
    chk("restart_oob", {31'b0, oob}, 32'h0);

    // negative value, 2-wide window
    strideMinusOne = 7'd1;
    pulse_run(7'd0);
    in0 = 32'hFFFF_FFF0; in1 = 7'd0;
    tick(); chk("neg_p0", out0, 32'hFFFF_FFF0);
    tick(); chk("neg_p1", out0, F);
    tick(); chk("neg_p0b", out0, 32'hFFFF_FFF0);

    // single-word windows
    strideMinusOne = 7'd0;
    pulse_run(7'd0);
    for (int i = 1; i <= 3; i++) begin
      in0 = 32'(i);
      tick(); chk($sformatf("s0_ramp%0d", i), out0, 32'(i));
    end
    pulse_run(7'd0);
    chk("s0_run_hold", out0, 32'h3);
    in1 = 7'd1;
    for (int i = 0; i < 2; i++) begin
      tick(); chk($sformatf("s0_oob_out%0d", i), out0, F);
    end
    chk("s0_oob", {31'b0, oob}, 32'h1);
    in1 = 7'd0; in0 = 32'h55;
    tick(); chk("s0_back", out0, 32'h55);

    // async reset mid-stream
    #2 rst = 1'b1;
    #1;
    chk("arst_out0", out0, 32'h0);
    chk("arst_oob", {31'b0, oob}, 32'h0);
    #1 rst = 1'b0;
    tick(); chk("idle_fill0", out0, F);
    tick(); chk("idle_fill1", out0, F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/f_max_unpool.md
Name: f_max_unpool

Overview:
- Inverse of the accumulate-max pooling unit.
- Takes one pooled value (in0) and its in-window argmax index (in1) per window, and expands it back into a stream of strideMinusOne+1 words.
- The pooled value appears at the argmax position; every other position carries a fill value.
- Sits in the Versat unit library as a functional unit for max-unpool / max-pool backward paths, with the same run/running/delay0 control as the pooling units.

Parameters:
DATA_W, 32, data width of in0/out0 (signed two's complement)
DELAY_W, 7, width of delay0, strideMinusOne and in1

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
run  input  1  one-cycle pulse; (re)starts the unit and loads delay0
running  input  1  advance enable; when low, all state and out0 hold
strideMinusOne  input  DELAY_W  window length minus 1 (static during a run)
delay0  input  DELAY_W  cycles to wait after run before the first window starts
in0  input  DATA_W  pooled value; sampled at window start
in1  input  DELAY_W  argmax position within the window; sampled at window start
out0  output  DATA_W  expanded stream; versat_latency = 1
oob  output  1  sticky: a sampled in1 exceeded strideMinusOne since the last run

Behaviour:
- Reset: state=IDLE, cnt=0, pos=0, val=0, idx=0, out0=0, oob=0.
- States: IDLE, WAIT, STREAM.
- run has priority over running and applies in any state:
  - delay0!=0 -> state=WAIT, cnt=delay0.
  - delay0==0 -> state=STREAM, pos=0.
  - In both cases oob clears.
  - out0 is not changed on a run cycle.
- Updates below happen only when running=1 and run=0. With running=0 everything holds.
- IDLE: out0 <= fill. No transitions other than run.
- WAIT: cnt decrements; when cnt==1, next state=STREAM with pos=0. out0 <= fill.
- STREAM:
  - pos==0 (window start): sample val<=in0, idx<=in1. If in1>strideMinusOne, set oob.
  - Window counter: pos==strideMinusOne -> pos<=0, else pos<=pos+1. Wraps indefinitely until the next run.
  - Output, registered with one-cycle latency: out0 <= (pos==eidx) ? eval : fill.
    - At pos==0, eidx/eval are in1/in0 (bypass).
    - Otherwise, eidx/eval are the registered idx/val.
- strideMinusOne==0: every STREAM cycle is a window start; out0 follows in0 one cycle later when in1==0, else fill.
- in1 out of range: the whole window outputs fill. No wrap or truncation of the index.
- run mid-window: the current window is abandoned immediately; no partial-window completion.
- Reset mid-operation: returns to the reset values above asynchronously.
- fill = 0 by default (see Optional Feature).

Optional Feature:
- Macro: F_MAX_UNPOOL_NEG_FILL_EN.
- Defined: fill = most-negative signed value ({1'b1,{DATA_W-1{1'b0}}}). Re-pooling the output with the accumulate-max unit then returns the original in0 exactly, including for negative values.
- Undefined: fill = 0, which is correct for gradient scatter.
- Reset value of out0 is 0 in both builds.

Decomposition:
- Package f_max_unpool_pkg holds:
  - state enum (IDLE/WAIT/STREAM, 2 bits)
  - FILL_ZERO constant
  - function fill_value(DATA_W)
- One natural sub-module: f_unpool_window_ctr. It holds the WAIT down-counter and the STREAM pos counter, and outputs pos, window_start and stream_active. The top level adds the sample registers, compare, output register and oob.

Test Plan:
- delay0=2, strideMinusOne=3, running=1, in0=0x00000007 / in1=2 at window start -> out0 = fill,fill (WAIT), then 0,0,7,0 repeating with in0 held.
- Negative value: in0=0xFFFFFFF0, in1=0, strideMinusOne=1, delay0=0 -> out0 = 0xFFFFFFF0,0,... With NEG_FILL_EN the fill words read 0x80000000.
- strideMinusOne=0, delay0=0, in0 ramp 1,2,3, in1=0 -> out0 = 1,2,3 one cycle later. Same with in1=1 -> all fill and oob=1.
- Stall: running=0 for 3 cycles mid-window at pos=1 -> out0 and pos frozen. Resuming completes the window with no skipped or duplicated positions.
- run pulse at pos=2 of a 4-wide window with delay0=1 -> window abandoned, one WAIT cycle, new window starts at pos 0, oob cleared.
- Assert rst during STREAM -> out0=0, oob=0, state IDLE immediately. After release, out0 stays at fill until run.
